// File: rtl/vga_draw_sprite.sv
// Sprite overlay stage: composites a 2^XB x 2^YB sprite fetched from an external
// pixel ROM onto the upstream colour, with per-frame shadowed position and colour keying.
module vga_draw_sprite #(
    parameter int unsigned XB      = 4,
    parameter int unsigned YB      = 4,
    parameter int unsigned ROM_LAT = 1,
    parameter logic [11:0] KEY     = 12'hF0F
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              sprite_en,
    input  logic              mirror_x,
    input  logic [11:0]       rgb_pixel,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out,
    output logic [YB+XB-1:0]  pixel_addr,
    output logic              frame_latch
);

    localparam logic [12:0] X_SPAN = 13'(2 ** XB);
    localparam logic [12:0] Y_SPAN = 13'(2 ** YB);

    typedef struct packed {
        logic        hit;
        logic [11:0] rgb;
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
    } pix_t;

    // Shadow registers, reloaded only on the rising edge of vblank
    logic        vblnk_prev_q;
    logic        vblnk_rise;
    logic [11:0] xs_q, xs_d;
    logic [11:0] ys_q, ys_d;
    logic        ens_q, ens_d;
    logic        mirs_q, mirs_d;
    logic        frame_latch_q;

    assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

    always_comb begin
        xs_d   = xs_q;
        ys_d   = ys_q;
        ens_d  = ens_q;
        mirs_d = mirs_q;
        if (vblnk_rise) begin
            xs_d   = xpos;
            ys_d   = ypos;
            ens_d  = sprite_en;
            mirs_d = mirror_x;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_prev_q  <= 1'b0;
            xs_q          <= '0;
            ys_q          <= '0;
            ens_q         <= 1'b0;
            mirs_q        <= 1'b0;
            frame_latch_q <= 1'b0;
        end else begin
            vblnk_prev_q  <= vblnk_in;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            ens_q         <= ens_d;
            mirs_q        <= mirs_d;
            frame_latch_q <= vblnk_rise;
        end
    end

    // Hit test in 13 bits so the right/bottom bound never wraps near 4095
    logic [12:0] h_ext, v_ext;
    logic [12:0] x_lo, x_hi, y_lo, y_hi;
    logic        hit_c;
    logic [XB-1:0] dx_c;
    logic [YB-1:0] dy_c;

    assign h_ext = {2'b00, hcount_in};
    assign v_ext = {2'b00, vcount_in};
    assign x_lo  = {1'b0, xs_q};
    assign y_lo  = {1'b0, ys_q};
    assign x_hi  = x_lo + X_SPAN;
    assign y_hi  = y_lo + Y_SPAN;

    assign hit_c = ens_q & (h_ext >= x_lo) & (h_ext < x_hi)
                         & (v_ext >= y_lo) & (v_ext < y_hi);

    assign dx_c = XB'(h_ext - x_lo);
    assign dy_c = YB'(v_ext - y_lo);

    // Inverting the x offset is (2^XB - 1) - dx
    assign pixel_addr = {dy_c, (mirs_q ? ~dx_c : dx_c)};

    // Delay line aligning hit, colour and timing with the ROM read data
    pix_t stage_in;
    pix_t aligned;
    pix_t dly_q [ROM_LAT];

    always_comb begin
        stage_in        = '0;
        stage_in.hit    = hit_c;
        stage_in.rgb    = rgb_in;
        stage_in.hcount = hcount_in;
        stage_in.vcount = vcount_in;
        stage_in.hsync  = hsync_in;
        stage_in.hblnk  = hblnk_in;
        stage_in.vsync  = vsync_in;
        stage_in.vblnk  = vblnk_in;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= stage_in;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign aligned = dly_q[ROM_LAT-1];

    // Output compositing: blanking first, then keyed sprite, then background
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, hblnk_q, vsync_q, vblnk_q;

    always_comb begin
        rgb_d = aligned.rgb;
        if (aligned.hblnk | aligned.vblnk) begin
            rgb_d = 12'h000;
        end else if (aligned.hit && (rgb_pixel != KEY)) begin
            rgb_d = rgb_pixel;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vsync_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hcount_q <= aligned.hcount;
            vcount_q <= aligned.vcount;
            hsync_q  <= aligned.hsync;
            hblnk_q  <= aligned.hblnk;
            vsync_q  <= aligned.vsync;
            vblnk_q  <= aligned.vblnk;
        end
    end

    assign rgb_out     = rgb_q;
    assign hcount_out  = hcount_q;
    assign vcount_out  = vcount_q;
    assign hsync_out   = hsync_q;
    assign hblnk_out   = hblnk_q;
    assign vsync_out   = vsync_q;
    assign vblnk_out   = vblnk_q;
    assign frame_latch = frame_latch_q;

endmodule

// File: tb/tb_vga_draw_sprite.sv
// Bench for vga_draw_sprite: two instances (ROM_LAT=1 and ROM_LAT=3) share one stimulus
// stream; a reference model feeds per-instance expectation queues.
module tb_vga_draw_sprite;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        sprite_en, mirror_x;

    // Requested register values, applied on the next drive
    logic [11:0] xpos_n, ypos_n;
    logic        en_n, mir_n;

    logic [10:0] hc1, vc1, hc3, vc3;
    logic        hs1, hb1, vs1, vb1, hs3, hb3, vs3, vb3;
    logic [11:0] rgb1, rgb3, rom1, rom3, r3a, r3b;
    logic [7:0]  addr1, addr3;
    logic        fl1, fl3;

    vga_draw_sprite #(.XB(4), .YB(4), .ROM_LAT(1), .KEY(12'hF0F)) u_dut1 (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .sprite_en(sprite_en), .mirror_x(mirror_x),
        .rgb_pixel(rom1),
        .hcount_out(hc1), .vcount_out(vc1),
        .hsync_out(hs1), .hblnk_out(hb1), .vsync_out(vs1), .vblnk_out(vb1),
        .rgb_out(rgb1), .pixel_addr(addr1), .frame_latch(fl1)
    );

    vga_draw_sprite #(.XB(4), .YB(4), .ROM_LAT(3), .KEY(12'hF0F)) u_dut3 (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .sprite_en(sprite_en), .mirror_x(mirror_x),
        .rgb_pixel(rom3),
        .hcount_out(hc3), .vcount_out(vc3),
        .hsync_out(hs3), .hblnk_out(hb3), .vsync_out(vs3), .vblnk_out(vb3),
        .rgb_out(rgb3), .pixel_addr(addr3), .frame_latch(fl3)
    );

    // ROM contents: value = address, except a key pixel and its neighbour
    function automatic logic [11:0] rom_f(input logic [7:0] a);
        case (a)
            8'h55:   return 12'hF0F;
            8'h56:   return 12'hF0E;
            default: return {4'h0, a};
        endcase
    endfunction

    always @(posedge pclk) begin
        rom1 <= rom_f(addr1);
        r3a  <= rom_f(addr3);
        r3b  <= r3a;
        rom3 <= r3b;
    end

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
    } exp_t;
    typedef struct packed { int due; exp_t e; } sb_t;
    typedef struct packed { int due; logic fl; } fl_t;

    sb_t sb1[$];
    sb_t sb3[$];
    fl_t flq[$];

    int checks   = 0;
    int failures = 0;

    int   m_xs = 0, m_ys = 0;
    logic m_en = 1'b0, m_mir = 1'b0, m_vbp = 1'b0;

    // One pixel per cycle; computes the expected result and advances the model
    task automatic drive(input int h, input int v, input logic hbv, input logic vbv,
                         input logic [11:0] c, input logic r);
        exp_t e;
        sb_t  s;
        fl_t  f;
        int   dx, dy, a;
        logic hit;
        logic [11:0] pix;
        @(negedge pclk);
        rst       = r;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = (h % 3 == 0);
        hblnk_in  = hbv;
        vsync_in  = vbv & (v % 2 == 1);
        vblnk_in  = vbv;
        rgb_in    = c;
        xpos      = xpos_n;
        ypos      = ypos_n;
        sprite_en = en_n;
        mirror_x  = mir_n;

        hit = m_en && (h >= m_xs) && (h < m_xs + 16) && (v >= m_ys) && (v < m_ys + 16);
        dx  = (h - m_xs) & 15;
        if (m_mir) dx = 15 - dx;
        dy  = (v - m_ys) & 15;
        a   = dy * 16 + dx;
        pix = rom_f(8'(a));
        e.hc = hcount_in; e.vc = vcount_in;
        e.hs = hsync_in;  e.hb = hbv; e.vs = vsync_in; e.vb = vbv;
        if (hbv || vbv)                  e.rgb = 12'h000;
        else if (hit && pix != 12'hF0F)  e.rgb = pix;
        else                             e.rgb = c;

        if (r) begin
            e = '0;
            for (int i = 0; i < sb1.size(); i++) begin
                s = sb1[i];
                if (s.due > cyc) begin s.e = '0; sb1[i] = s; end
            end
            for (int i = 0; i < sb3.size(); i++) begin
                s = sb3[i];
                if (s.due > cyc) begin s.e = '0; sb3[i] = s; end
            end
        end
        s.due = cyc + 2; s.e = e; sb1.push_back(s);
        s.due = cyc + 4;          sb3.push_back(s);
        f.due = cyc + 1; f.fl = !r && vbv && !m_vbp; flq.push_back(f);

        if (r) begin
            m_xs = 0; m_ys = 0; m_en = 1'b0; m_mir = 1'b0; m_vbp = 1'b0;
        end else begin
            if (vbv && !m_vbp) begin
                m_xs = int'(xpos); m_ys = int'(ypos); m_en = sprite_en; m_mir = mirror_x;
            end
            m_vbp = vbv;
        end
    endtask

    // Scoreboard: pop and compare each expectation on its due cycle
    always @(negedge pclk) begin
        sb_t s;
        fl_t f;
        while (sb1.size() > 0 && sb1[0].due <= cyc) begin
            s = sb1.pop_front();
            checks++;
            if (rgb1 !== s.e.rgb) begin
                failures++;
                $display("FAIL sb_rgb_lat1 cyc=%0d got=%h exp=%h", cyc, rgb1, s.e.rgb);
            end
            checks++;
            if ({hc1, vc1, hs1, hb1, vs1, vb1} !== {s.e.hc, s.e.vc, s.e.hs, s.e.hb, s.e.vs, s.e.vb}) begin
                failures++;
                $display("FAIL sb_timing_lat1 cyc=%0d got=%h exp=%h", cyc,
                         {hc1, vc1, hs1, hb1, vs1, vb1}, {s.e.hc, s.e.vc, s.e.hs, s.e.hb, s.e.vs, s.e.vb});
            end
        end
        while (sb3.size() > 0 && sb3[0].due <= cyc) begin
            s = sb3.pop_front();
            checks++;
            if (rgb3 !== s.e.rgb) begin
                failures++;
                $display("FAIL sb_rgb_lat3 cyc=%0d got=%h exp=%h", cyc, rgb3, s.e.rgb);
            end
            checks++;
            if ({hc3, vc3, hs3, hb3, vs3, vb3} !== {s.e.hc, s.e.vc, s.e.hs, s.e.hb, s.e.vs, s.e.vb}) begin
                failures++;
                $display("FAIL sb_timing_lat3 cyc=%0d got=%h exp=%h", cyc,
                         {hc3, vc3, hs3, hb3, vs3, vb3}, {s.e.hc, s.e.vc, s.e.hs, s.e.hb, s.e.vs, s.e.vb});
            end
        end
        while (flq.size() > 0 && flq[0].due <= cyc) begin
            f = flq.pop_front();
            checks++;
            if ({fl1, fl3} !== {2{f.fl}}) begin
                failures++;
                $display("FAIL sb_frame_latch cyc=%0d got=%b%b exp=%b", cyc, fl1, fl3, f.fl);
            end
        end
    end

    task automatic do_vblank();
        repeat (3) drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b0);
        drive(0, 0, 1'b0, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            xpos_n = 12'($urandom); ypos_n = 12'($urandom);
            en_n = 1'b1; mir_n = 1'($urandom);
            drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                  1'($urandom), 1'($urandom), 12'($urandom), 1'b1);
        end
        checks++;
        if ({rgb1, hc1, vc1, hs1, hb1, vs1, vb1, fl1} !== 38'h0) begin
            failures++;
            $display("FAIL reset_outputs_lat1 got=%h exp=0", {rgb1, hc1, vc1, hs1, hb1, vs1, vb1, fl1});
        end
        checks++;
        if ({rgb3, hc3, vc3, hs3, hb3, vs3, vb3, fl3} !== 38'h0) begin
            failures++;
            $display("FAIL reset_outputs_lat3 got=%h exp=0", {rgb3, hc3, vc3, hs3, hb3, vs3, vb3, fl3});
        end
    endtask

    task automatic test_first_frame();
        int fl_cnt = 0;
        xpos_n = 12'd100; ypos_n = 12'd50; en_n = 1'b1; mir_n = 1'b0;
        for (int h = 96; h <= 104; h++) begin
            drive(h, 50, 1'b0, 1'b0, 12'h123, 1'b0);
            fl_cnt += int'(fl1);
            if (h - 2 == 100) begin
                checks++;
                if (rgb1 !== 12'h123) begin
                    failures++;
                    $display("FAIL first_frame_hidden got=%h exp=123", rgb1);
                end
            end
        end
        checks++;
        if (fl_cnt !== 0) begin
            failures++;
            $display("FAIL first_frame_no_latch got=%0d exp=0", fl_cnt);
        end
    endtask

    task automatic test_placement();
        xpos_n = 12'd100; ypos_n = 12'd50; en_n = 1'b1; mir_n = 1'b0;
        drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b0);
        drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b0);
        checks++;
        if (fl1 !== 1'b1) begin failures++; $display("FAIL frame_latch_pulse got=%b exp=1", fl1); end
        drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b0);
        checks++;
        if (fl1 !== 1'b0) begin failures++; $display("FAIL frame_latch_single got=%b exp=0", fl1); end
        drive(0, 0, 1'b0, 1'b0, 12'h000, 1'b0);
        for (int h = 96; h <= 118; h++) begin
            drive(h, 50, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h == 100) begin
                #1;
                checks++;
                if (addr1 !== 8'h00) begin failures++; $display("FAIL addr_100_50 got=%h exp=00", addr1); end
            end
            if (h - 2 == 100) begin
                checks++;
                if (rgb1 !== 12'h000) begin failures++; $display("FAIL place_100_50 got=%h exp=000", rgb1); end
            end
            if (h - 2 == 99) begin
                checks++;
                if (rgb1 !== 12'h123) begin failures++; $display("FAIL place_99_50 got=%h exp=123", rgb1); end
            end
            if (h - 2 == 116) begin
                checks++;
                if (rgb1 !== 12'h123) begin failures++; $display("FAIL place_116_50 got=%h exp=123", rgb1); end
            end
        end
        for (int h = 110; h <= 119; h++) begin
            drive(h, 65, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 115) begin
                checks++;
                if (rgb1 !== 12'h0FF) begin failures++; $display("FAIL place_115_65 got=%h exp=0FF", rgb1); end
            end
        end
    endtask

    task automatic test_transparency();
        for (int h = 103; h <= 110; h++) begin
            drive(h, 55, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 105) begin
                checks++;
                if (rgb1 !== 12'h123) begin failures++; $display("FAIL key_105_55 got=%h exp=123", rgb1); end
            end
            if (h - 2 == 106) begin
                checks++;
                if (rgb1 !== 12'hF0E) begin failures++; $display("FAIL nearkey_106_55 got=%h exp=F0E", rgb1); end
            end
        end
    endtask

    task automatic test_mirror();
        mir_n = 1'b1;
        do_vblank();
        for (int h = 98; h <= 118; h++) begin
            drive(h, 50, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h == 100 || h == 115) begin
                #1;
                checks++;
                if (addr1 !== ((h == 100) ? 8'h0F : 8'h00)) begin
                    failures++;
                    $display("FAIL mirror_addr h=%0d got=%h exp=%h", h, addr1, (h == 100) ? 8'h0F : 8'h00);
                end
            end
            if (h - 2 == 100) begin
                checks++;
                if (rgb1 !== 12'h00F) begin failures++; $display("FAIL mirror_rgb_100_50 got=%h exp=00F", rgb1); end
            end
        end
        mir_n = 1'b0;
    endtask

    task automatic test_frame_coherence();
        int fl_cnt = 0;
        xpos_n = 12'd100;
        do_vblank();
        xpos_n = 12'd200;
        for (int h = 98; h <= 104; h++) begin
            drive(h, 60, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 100) begin
                checks++;
                if (rgb1 !== 12'h0A0) begin failures++; $display("FAIL coherent_old_pos got=%h exp=0A0", rgb1); end
            end
        end
        drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b0);
        xpos_n = 12'd300;
        repeat (4) begin
            drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b0);
            fl_cnt += int'(fl1);
        end
        drive(0, 0, 1'b0, 1'b0, 12'h000, 1'b0);
        fl_cnt += int'(fl1);
        checks++;
        if (fl_cnt !== 1) begin failures++; $display("FAIL coherent_latch_count got=%0d exp=1", fl_cnt); end
        for (int h = 198; h <= 204; h++) begin
            drive(h, 60, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 200) begin
                checks++;
                if (rgb1 !== 12'h0A0) begin failures++; $display("FAIL coherent_new_pos got=%h exp=0A0", rgb1); end
            end
        end
        for (int h = 298; h <= 304; h++) begin
            drive(h, 60, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 300) begin
                checks++;
                if (rgb1 !== 12'h123) begin failures++; $display("FAIL coherent_ignored_pos got=%h exp=123", rgb1); end
            end
        end
    endtask

    task automatic test_latency_clip();
        int hist_h[$];
        logic [11:0] hist_c[$];
        logic [11:0] c;
        int bad = 0;
        xpos_n = 12'd4090;
        do_vblank();
        for (int h = 0; h < 800; h++) begin
            c = 12'($urandom);
            drive(h, 50, 1'b0, 1'b0, c, 1'b0);
            hist_h.push_back(h);
            hist_c.push_back(c);
            if (hist_h.size() > 4) begin
                if (hc3 !== 11'(hist_h[hist_h.size() - 5])) bad++;
                if (rgb3 !== hist_c[hist_c.size() - 5]) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL lat4_clip_line got=%0d_bad exp=0_bad", bad); end
        checks++;
        if (hc3 !== 11'd795) begin failures++; $display("FAIL lat4_hcount_end got=%0d exp=795", hc3); end
    endtask

    task automatic test_blanking();
        xpos_n = 12'd100;
        do_vblank();
        for (int h = 96; h <= 106; h++) begin
            drive(h, 50, 1'b1, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 100) begin
                checks++;
                if (rgb1 !== 12'h000) begin failures++; $display("FAIL blank_lat1 got=%h exp=000", rgb1); end
            end
            if (h - 4 == 100) begin
                checks++;
                if ({rgb3, hb3} !== 13'h0001) begin failures++; $display("FAIL blank_lat3 got=%h exp=0001", {rgb3, hb3}); end
            end
        end
    endtask

    task automatic test_midframe_reset();
        for (int h = 96; h <= 101; h++) drive(h, 50, 1'b0, 1'b0, 12'h123, 1'b0);
        drive(102, 50, 1'b0, 1'b0, 12'h123, 1'b1);
        for (int h = 103; h <= 110; h++) begin
            drive(h, 50, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h == 103) begin
                checks++;
                if ({rgb1, hc1, rgb3, hc3} !== 46'h0) begin
                    failures++;
                    $display("FAIL midreset_flush got=%h exp=0", {rgb1, hc1, rgb3, hc3});
                end
            end
            if (h - 2 == 103) begin
                checks++;
                if (rgb1 !== 12'h123) begin failures++; $display("FAIL midreset_hidden got=%h exp=123", rgb1); end
            end
        end
    endtask

    task automatic test_reset_with_edge();
        drive(0, 600, 1'b1, 1'b1, 12'h000, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 12'h000, 1'b0);
        checks++;
        if (fl1 !== 1'b0) begin failures++; $display("FAIL rst_edge_latch got=%b exp=0", fl1); end
        for (int h = 98; h <= 104; h++) begin
            drive(h, 50, 1'b0, 1'b0, 12'h123, 1'b0);
            if (h - 2 == 100) begin
                checks++;
                if (rgb1 !== 12'h123) begin failures++; $display("FAIL rst_edge_hidden got=%h exp=123", rgb1); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_vblank();
        for (int v = 50; v <= 51; v++) begin
            for (int h = 99; h <= 104; h++) begin
                drive(h, v, 1'b0, 1'b0, 12'h456, 1'b0);
                if (h - 2 == 101) begin
                    checks++;
                    if (rgb1 !== ((v == 50) ? 12'h001 : 12'h011)) begin
                        failures++;
                        $display("FAIL b2b_v%0d got=%h exp=%h", v, rgb1, (v == 50) ? 12'h001 : 12'h011);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = '0; xpos = '0; ypos = '0; sprite_en = 1'b0; mirror_x = 1'b0;
        xpos_n = '0; ypos_n = '0; en_n = 1'b0; mir_n = 1'b0;

        test_reset();
        test_first_frame();
        test_placement();
        test_transparency();
        test_mirror();
        test_frame_coherence();
        test_latency_clip();
        test_blanking();
        test_midframe_reset();
        test_reset_with_edge();
        xpos_n = 12'd100; ypos_n = 12'd50; en_n = 1'b1;
        test_back_to_back();
        repeat (6) drive(0, 0, 1'b0, 1'b0, 12'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_draw_sprite.md
# vga_draw_sprite

Parametrised sprite overlay stage for the VGA pixel pipeline. It sits in the timing chain after the background/rectangle stages and composites a 2^XB × 2^YB sprite, fetched from an external pixel ROM with configurable read latency, onto `rgb_in`. Sprite position, enable and horizontal mirror are latched once per frame at the start of vertical blanking, which eliminates tearing. Pixels equal to a colour key are transparent.

## Interface
Parameters:
- `XB`, 4: sprite width is 2^XB pixels (1..6).
- `YB`, 4: sprite height is 2^YB lines (1..6).
- `ROM_LAT`, 1: cycles from `pixel_addr` to valid `rgb_pixel` (1..4).
- `KEY`, 12'hF0F: transparent colour key.

Ports:
- `pclk` in 1: pixel clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `hcount_in`, `vcount_in` in 11 each: pixel coordinates.
- `hsync_in`, `hblnk_in`, `vsync_in`, `vblnk_in` in 1 each: timing.
- `rgb_in` in 12: upstream colour.
- `xpos`, `ypos` in 12 each: requested sprite top-left corner.
- `sprite_en` in 1: requested sprite visibility.
- `mirror_x` in 1: requested horizontal flip.
- `rgb_pixel` in 12: ROM data, valid `ROM_LAT` cycles after its address.
- `hcount_out`, `vcount_out` out 11 each: delayed timing.
- `hsync_out`, `hblnk_out`, `vsync_out`, `vblnk_out` out 1 each: delayed timing.
- `rgb_out` out 12: composited colour.
- `pixel_addr` out YB+XB: ROM address, `{dy[YB-1:0], dx[XB-1:0]}`.
- `frame_latch` out 1: one-cycle pulse on the cycle after shadow registers update.

## Operation
- Shadow registers hold `xs`, `ys`, `ens` and `mirs`. They load from `xpos`, `ypos`, `sprite_en` and `mirror_x` on a cycle where `vblnk_in`=1 and the registered previous `vblnk_in`=0 (rising edge). At all other times they hold.
- Hit test (stage 0, combinational on inputs): `hit` = `ens` & (hcount_in ≥ xs) & (hcount_in < xs+2^XB) & (vcount_in ≥ ys) & (vcount_in < ys+2^YB).
  - All operands are zero-extended to 13 bits, so xs+2^XB never wraps. A sprite at xs=4090 is clipped, never wrapped.
- dx = hcount_in − xs and dy = vcount_in − ys, truncated to XB and YB bits.
  - If `mirs`=1, the x field is (2^XB−1) − dx.
  - `pixel_addr` is driven combinationally every cycle, including when `hit`=0 (value irrelevant then).
- Delay line: `hit`, `rgb_in` and all six timing inputs pass through `ROM_LAT` register stages to align with `rgb_pixel`.
- Output stage (one register), using the aligned values:
  - If blank (aligned hblnk | vblnk): `rgb_out` = 0.
  - Else if hit and `rgb_pixel` ≠ KEY: `rgb_out` = `rgb_pixel`.
  - Else: `rgb_out` = aligned `rgb_in`.
  - The timing outputs are registered in the same stage.
- Reset: every pipeline stage, every output, the shadow registers (`ens`=0, so nothing is drawn) and the edge-detect register clear to 0. Reset mid-frame discards the in-flight pixels. The sprite stays invisible until the first vblank rising edge after reset.

## Timing
- Latency from any input (timing, `rgb_in`) to the matching output is `ROM_LAT`+1 cycles, constant, with no stalls.
- `pixel_addr` has zero latency from `hcount_in` / `vcount_in`.
- Shadow update takes effect for the pixel presented in the cycle after the edge.
  - The edge cycle itself uses the old values, which is harmless because vblank is active.
  - `frame_latch` is high in that following cycle.
- If `xpos` changes while vblnk is already high, the change is ignored until the next frame's edge.
- Simultaneous `rst` and vblank edge: reset wins, and the shadows stay 0.
- Throughput: one pixel per `pclk`.

## Test plan
- Reset: hold `rst` for 3 cycles with random inputs → all outputs 0, `frame_latch`=0; no sprite is drawn in the first frame even with `sprite_en`=1.
- Placement (XB=YB=4, ROM_LAT=1, ROM = address value, `rgb_in`=12'h123): xpos=100, ypos=50, latch at vblank.
  - Pixel (100,50) → `rgb_out`=12'h000 (addr 0).
  - Pixel (115,65) → 12'h0FF.
  - Pixels (99,50) and (116,50) → 12'h123.
  - All of these appear 2 cycles after input.
- Transparency: ROM returns 12'hF0F at pixel (105,55) → `rgb_out`=`rgb_in` there; an adjacent ROM value of 12'hF0E is drawn.
- Mirror: `mirror_x`=1, same placement → pixel (100,50) gives `pixel_addr`=8'h0F; pixel (115,50) gives 8'h00.
- Frame coherence: change xpos 100→200 mid-frame → the rest of that frame is still drawn at 100; after the vblank edge `frame_latch` pulses once and the sprite appears at 200.
- Latency / clipping (ROM_LAT=3): timing outputs lag inputs by exactly 4 cycles; xpos=4090 produces no hit anywhere on an 800-wide line; blanking forces `rgb_out`=0 even when hit.
